// File: rtl/oser10.sv
// 10:1 parallel-to-serial converter for one TMDS channel, with word-boundary strobe.
// Optional ones-count of each sampled character is built when OSER10_POPCOUNT_EN is defined.
module oser10 #(
    parameter int unsigned LSB_FIRST = 1
) (
    input  logic       FCLK,
    input  logic       RESETN,
    input  logic [9:0] D,
    output logic       Q,
    output logic       LOAD,
    output logic [3:0] ONES
);

    localparam int unsigned W    = 10;
    localparam int unsigned CW   = 4;
    localparam bit          LSBF = (LSB_FIRST != 0);

    logic [CW-1:0] cnt;
    logic [W-1:0]  shreg;
    logic [W-1:0]  shreg_nxt;
    logic          load_edge_c;

    assign load_edge_c = (cnt == CW'(W - 1));

    // Phase counter 0..9 and strobe registered one cycle early so it sits on cnt==9
    always_ff @(posedge FCLK or negedge RESETN) begin
        if (!RESETN) begin
            cnt  <= '0;
            LOAD <= 1'b0;
        end else begin
            cnt  <= load_edge_c ? '0 : cnt + CW'(1);
            LOAD <= (cnt == CW'(W - 2));
        end
    end

    always_comb begin
        shreg_nxt = '0;
        if (load_edge_c) begin
            shreg_nxt = D;
        end else if (LSBF) begin
            shreg_nxt = {1'b0, shreg[W-1:1]};
        end else begin
            shreg_nxt = {shreg[W-2:0], 1'b0};
        end
    end

    always_ff @(posedge FCLK or negedge RESETN) begin
        if (!RESETN) begin
            shreg <= '0;
        end else begin
            shreg <= shreg_nxt;
        end
    end

    // Output end of the shift register drives the pad directly
    assign Q = LSBF ? shreg[0] : shreg[W-1];

`ifdef OSER10_POPCOUNT_EN
    logic [1:0]    pair_sum [5];
    logic [2:0]    quad_lo;
    logic [2:0]    quad_hi;
    logic [CW-1:0] ones_c;

    // Balanced adder tree: five bit pairs, two quads, final sum with the fifth pair
    always_comb begin
        for (int i = 0; i < 5; i++) begin
            pair_sum[i] = {1'b0, D[2*i]} + {1'b0, D[2*i+1]};
        end
        quad_lo = {1'b0, pair_sum[0]} + {1'b0, pair_sum[1]};
        quad_hi = {1'b0, pair_sum[2]} + {1'b0, pair_sum[3]};
        ones_c  = {1'b0, quad_lo} + {1'b0, quad_hi} + {2'b00, pair_sum[4]};
    end

    always_ff @(posedge FCLK or negedge RESETN) begin
        if (!RESETN) begin
            ONES <= '0;
        end else if (load_edge_c) begin
            ONES <= ones_c;
        end
    end
`else
    assign ONES = '0;
`endif

endmodule

// File: tb/tb_oser10.sv
// Self-checking bench for oser10: both bit orders side by side against a word-level model.
// Model tracks cycle index since reset release and the last sampled character.
module tb_oser10;

    logic       FCLK = 1'b0;
    logic       RESETN = 1'b0;
    logic [9:0] D = '0;
    logic       q_lsb, load_lsb, q_msb, load_msb;
    logic [3:0] ones_lsb, ones_msb;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int         cyc = 0;
    logic [9:0] word = '0;
    int         start = 0;
    bit         have = 1'b0;

    oser10 #(.LSB_FIRST(1)) dut (
        .FCLK(FCLK), .RESETN(RESETN), .D(D), .Q(q_lsb), .LOAD(load_lsb), .ONES(ones_lsb)
    );
    oser10 #(.LSB_FIRST(0)) dut_msb (
        .FCLK(FCLK), .RESETN(RESETN), .D(D), .Q(q_msb), .LOAD(load_msb), .ONES(ones_msb)
    );

    always #5 FCLK = ~FCLK;

    function automatic logic exp_q(input bit lsb);
        int k;
        if (!have) return 1'b0;
        k = cyc - start;
        return lsb ? word[k] : word[9-k];
    endfunction

    function automatic logic exp_load();
        return (cyc % 10) == 9;
    endfunction

    function automatic logic [3:0] exp_ones();
`ifdef OSER10_POPCOUNT_EN
        return have ? 4'($countones(word)) : 4'd0;
`else
        return 4'd0;
`endif
    endfunction

    // Advance one bit cycle: model captures D on the edge ending a cnt==9 cycle
    task automatic tick();
        @(posedge FCLK);
        if (RESETN) begin
            if ((cyc % 10) == 9) begin
                word  = D;
                start = cyc + 1;
                have  = 1'b1;
            end
            cyc++;
        end
        #1;
    endtask

    task automatic model_reset();
        cyc  = 0;
        have = 1'b0;
    endtask

    task automatic test_reset();
        RESETN = 1'b0;
        D = 10'h3FF;
        model_reset();
        for (int i = 0; i < 12; i++) begin
            tick();
            checks++;
            if ({q_lsb, load_lsb, ones_lsb, q_msb, load_msb, ones_msb} !== 12'd0) begin
                errors++;
                $display("FAIL reset_hold cyc=%0d got q=%b load=%b ones=%0d q_msb=%b load_msb=%b ones_msb=%0d want all 0",
                         i, q_lsb, load_lsb, ones_lsb, q_msb, load_msb, ones_msb);
            end
        end
        RESETN = 1'b1;
        model_reset();
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (load_lsb !== (i == 9) || load_msb !== (i == 9)) begin
                errors++;
                $display("FAIL reset_first_load cycle=%0d got load=%b/%b want %b", i, load_lsb, load_msb, i == 9);
            end
            checks++;
            if (q_lsb !== 1'b0 || q_msb !== 1'b0) begin
                errors++;
                $display("FAIL reset_q_zero cycle=%0d got q=%b/%b want 0", i, q_lsb, q_msb);
            end
            tick();
        end
    endtask

    task automatic test_stream_lsb();
        logic [9:0] pat;
        int         since_load;
        pat = 10'b1101010100;
        D = pat;
        since_load = -1;
        for (int i = 0; i < 40; i++) begin
            tick();
            checks++;
            if (q_lsb !== exp_q(1'b1) || load_lsb !== exp_load()) begin
                errors++;
                $display("FAIL stream_lsb cyc=%0d got q=%b load=%b want q=%b load=%b",
                         cyc, q_lsb, load_lsb, exp_q(1'b1), exp_load());
            end
            if (load_lsb === 1'b1) begin
                checks++;
                if (since_load != -1 && since_load != 10) begin
                    errors++;
                    $display("FAIL stream_load_period got %0d want 10", since_load);
                end
                since_load = 0;
            end
            if (since_load >= 0) since_load++;
        end
    endtask

    task automatic test_sampling_window();
        D = 10'h000;
        for (int i = 0; i < 12; i++) tick();
        for (int i = 0; i < 10 && (cyc % 10) != 4; i++) tick();
        checks++;
        if ((cyc % 10) != 4) begin
            errors++;
            $display("FAIL window_phase got %0d want 4", cyc % 10);
        end
        D = 10'h3FF;
        tick();
        tick();
        D = 10'h000;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (q_lsb !== 1'b0 || q_msb !== 1'b0 || q_lsb !== exp_q(1'b1)) begin
                errors++;
                $display("FAIL window_q cyc=%0d got q=%b/%b want 0", cyc, q_lsb, q_msb);
            end
        end
    endtask

    task automatic test_popcount();
        logic [9:0] vals [3];
        vals[0] = 10'h3FF;
        vals[1] = 10'h000;
        vals[2] = 10'b0010101011;
        for (int w = 0; w < 3; w++) begin
            while ((cyc % 10) != 9) tick();
            D = vals[w];
            for (int i = 0; i < 10; i++) begin
                tick();
                checks++;
                if (ones_lsb !== exp_ones() || ones_msb !== exp_ones()) begin
                    errors++;
                    $display("FAIL popcount word=%0d cyc=%0d got %0d/%0d want %0d",
                             w, cyc, ones_lsb, ones_msb, exp_ones());
                end
            end
        end
    endtask

    task automatic test_msb_order();
        D = 10'b1101010100;
        for (int i = 0; i < 30; i++) begin
            tick();
            checks++;
            if (q_msb !== exp_q(1'b0) || load_msb !== exp_load()) begin
                errors++;
                $display("FAIL msb_order cyc=%0d got q=%b load=%b want q=%b load=%b",
                         cyc, q_msb, load_msb, exp_q(1'b0), exp_load());
            end
        end
    endtask

    task automatic test_midword_reset();
        D = 10'($urandom);
        for (int i = 0; i < 12 && (cyc % 10) != 4; i++) tick();
        RESETN = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({q_lsb, load_lsb, ones_lsb, q_msb, load_msb, ones_msb} !== 12'd0) begin
            errors++;
            $display("FAIL midword_reset_async got q=%b load=%b ones=%0d q_msb=%b load_msb=%b ones_msb=%0d want all 0",
                     q_lsb, load_lsb, ones_lsb, q_msb, load_msb, ones_msb);
        end
        tick();
        tick();
        RESETN = 1'b1;
        model_reset();
        D = 10'($urandom);
        for (int i = 0; i < 25; i++) begin
            checks++;
            if (q_lsb !== exp_q(1'b1) || q_msb !== exp_q(1'b0) || load_lsb !== exp_load() ||
                load_msb !== exp_load() || ones_lsb !== exp_ones()) begin
                errors++;
                $display("FAIL midword_recover cyc=%0d got q=%b/%b load=%b/%b ones=%0d want q=%b/%b load=%b ones=%0d",
                         cyc, q_lsb, q_msb, load_lsb, load_msb, ones_lsb,
                         exp_q(1'b1), exp_q(1'b0), exp_load(), exp_ones());
            end
            tick();
        end
    endtask

    task automatic test_random_stream();
        for (int i = 0; i < 300; i++) begin
            D = 10'($urandom);
            tick();
            checks++;
            if (q_lsb !== exp_q(1'b1) || q_msb !== exp_q(1'b0) || load_lsb !== exp_load() ||
                load_msb !== exp_load() || ones_lsb !== exp_ones() || ones_msb !== exp_ones()) begin
                errors++;
                $display("FAIL random_stream cyc=%0d got q=%b/%b load=%b/%b ones=%0d/%0d want q=%b/%b load=%b ones=%0d",
                         cyc, q_lsb, q_msb, load_lsb, load_msb, ones_lsb, ones_msb,
                         exp_q(1'b1), exp_q(1'b0), exp_load(), exp_ones());
            end
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_stream_lsb();
        test_sampling_window();
        test_popcount();
        test_msb_order();
        test_midword_reset();
        test_random_stream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
